// File: rtl/mem_traffic_pkg.sv
// rtl/mem_traffic_pkg.sv - shared encodings for the memory traffic checker
package mem_traffic_pkg;

    // Width of one pattern lane; DATA_W is a whole number of lanes
    localparam int LANE_W = 32;

    // Run modes
    localparam logic [1:0] MODE_WR_RD   = 2'b00;
    localparam logic [1:0] MODE_WR_ONLY = 2'b01;
    localparam logic [1:0] MODE_RD_ONLY = 2'b10;
    localparam logic [1:0] MODE_CONT    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_pattern_gen.sv
// rtl/mem_pattern_gen.sv - combinational per-entry data pattern generator
module mem_pattern_gen
    import mem_traffic_pkg::*;
#(
    parameter int DATA_W = 256
) (
    input  logic [LANE_W-1:0] seed_i,
    input  logic [15:0]       idx_i,
    output logic [DATA_W-1:0] pattern_o
);

    localparam int NUM_LANES = DATA_W / LANE_W;

    // Each lane mixes the entry index (upper half) and lane number (lower half) into the seed
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign pattern_o[k*LANE_W +: LANE_W] = seed_i ^ {idx_i, 16'(k)};
    end

endmodule

// File: rtl/mem_traffic_checker.sv
// rtl/mem_traffic_checker.sv - memory port write/read-back traffic generator and checker
module mem_traffic_checker
    import mem_traffic_pkg::*;
#(
    parameter int          DATA_W      = 256,
    parameter int          ADDR_W      = 28,
    parameter int          NUM_ENTRIES = 36,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned ADDR_STRIDE = 32,
    parameter int          CYCLE_DELAY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [31:0]       seed,
    output logic [DATA_W-1:0] mem_data_wr,
    input  logic [DATA_W-1:0] mem_data_rd,
    output logic [ADDR_W-1:0] mem_data_addr,
    output logic              mem_rw_data,
    output logic              mem_valid_data,
    input  logic              mem_ready_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [15:0]       pass_count
);

    localparam logic [15:0]       LAST_IDX = 16'(NUM_ENTRIES - 1);
    // Loaded on entering GAP; counting down to zero yields CYCLE_DELAY idle cycles
    localparam logic [7:0]        GAP_LOAD = 8'(CYCLE_DELAY - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ADDR_STRIDE);

    state_t              state_q, state_d;
    state_t              pend_q, pend_d;
    state_t              target;
    logic [15:0]         idx_q, idx_d;
    logic [7:0]          gap_q, gap_d;
    logic [1:0]          mode_q, mode_d;
    logic [31:0]         seed_q, seed_d;
    logic                error_q, error_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [15:0]         pass_count_q, pass_count_d;

    logic [DATA_W-1:0]   pattern;
    logic [ADDR_W-1:0]   cur_addr;
    logic                cmd_valid;
    logic                cmd_done;
    logic                last_entry;

    // One generator serves both the write data and the read-back compare
    mem_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .seed_i    (seed_q),
        .idx_i     (idx_q),
        .pattern_o (pattern)
    );

    // Address wraps naturally modulo 2**ADDR_W
    assign cur_addr   = BASE + STRIDE * ADDR_W'(idx_q);
    assign cmd_valid  = (state_q == ST_WR) || (state_q == ST_RD);
    assign cmd_done   = cmd_valid && mem_ready_data;
    assign last_entry = (idx_q == LAST_IDX);

    // Command outputs are forced to zero outside WR/RD so reset drops them immediately
    assign mem_valid_data = cmd_valid;
    assign mem_rw_data    = (state_q == ST_WR);
    assign mem_data_addr  = cmd_valid ? cur_addr : '0;
    assign mem_data_wr    = (state_q == ST_WR) ? pattern : '0;
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done           = (state_q == ST_DONE);
    assign error          = error_q;
    assign err_count      = err_count_q;
    assign fail_addr      = fail_addr_q;
    assign pass_count     = pass_count_q;

    // Next-state, index sequencing, compare and status update
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        target       = state_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        mode_d       = mode_q;
        seed_d       = seed_q;
        error_d      = error_q;
        err_count_d  = err_count_q;
        fail_addr_d  = fail_addr_q;
        pass_count_d = pass_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seed_d       = seed;
                    mode_d       = mode;
                    idx_d        = '0;
                    error_d      = 1'b0;
                    err_count_d  = '0;
                    fail_addr_d  = '0;
                    pass_count_d = '0;
                    state_d      = (mode == MODE_RD_ONLY) ? ST_RD : ST_WR;
                end
            end
            ST_WR: begin
                if (mem_ready_data) begin
                    if (last_entry) begin
                        idx_d  = '0;
                        target = (mode_q == MODE_WR_ONLY) ? ST_DONE : ST_RD;
                    end else begin
                        idx_d  = idx_q + 16'd1;
                        target = ST_WR;
                    end
                end
            end
            ST_RD: begin
                if (mem_ready_data) begin
                    if (mem_data_rd != pattern) begin
                        error_d = 1'b1;
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                        if (err_count_q == 16'd0) begin
                            fail_addr_d = cur_addr;
                        end
                    end
                    if (last_entry) begin
                        idx_d        = '0;
                        pass_count_d = pass_count_q + 16'd1;
                        if ((mode_q == MODE_CONT) && start) begin
                            mode_d = mode;
                            target = (mode == MODE_RD_ONLY) ? ST_RD : ST_WR;
                        end else begin
                            target = ST_DONE;
                        end
                    end else begin
                        idx_d  = idx_q + 16'd1;
                        target = ST_RD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = pend_q;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Idle gap is inserted only between commands, never before DONE
        if (cmd_done) begin
            if ((CYCLE_DELAY > 0) && (target != ST_DONE)) begin
                state_d = ST_GAP;
                pend_d  = target;
                gap_d   = GAP_LOAD;
            end else begin
                state_d = target;
            end
        end
    end

    // State and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pend_q       <= ST_IDLE;
            idx_q        <= '0;
            gap_q        <= '0;
            mode_q       <= '0;
            seed_q       <= '0;
            error_q      <= 1'b0;
            err_count_q  <= '0;
            fail_addr_q  <= '0;
            pass_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            mode_q       <= mode_d;
            seed_q       <= seed_d;
            error_q      <= error_d;
            err_count_q  <= err_count_d;
            fail_addr_q  <= fail_addr_d;
            pass_count_q <= pass_count_d;
        end
    end

endmodule

// File: tb/tb_mem_traffic_checker.sv
// tb/tb_mem_traffic_checker.sv - randomized self-checking bench for mem_traffic_checker
module tb_mem_traffic_checker;

    localparam int DW = 256;
    localparam int AW = 28;
    localparam int          N0  = 4;
    localparam int          CD0 = 0;
    localparam int unsigned B0  = 32'h100;
    localparam int unsigned S0  = 32;
    localparam int          N1  = 5;
    localparam int          CD1 = 3;
    localparam int unsigned B1  = 32'hFFF_FFC0;
    localparam int unsigned S1  = 32;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start [2];
    logic [1:0]    mode [2];
    logic [31:0]   seed [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] rdata [2];
    logic [AW-1:0] addr [2];
    logic [AW-1:0] fail_addr [2];
    logic          rw [2];
    logic          valid [2];
    logic          ready [2];
    logic          busy [2];
    logic          done [2];
    logic          error [2];
    logic [15:0]   err_count [2];
    logic [15:0]   pass_count [2];

    int   total = 0;
    int   bad = 0;
    cmd_t log0 [$];
    cmd_t log1 [$];
    logic [DW-1:0] mem [logic [AW:0]];
    int   corrupt_idx [2];
    int   lat_lo [2];
    int   lat_hi [2];

    always #5 clk = ~clk;

    mem_traffic_checker #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_ENTRIES(N0), .BASE_ADDR(B0), .ADDR_STRIDE(S0), .CYCLE_DELAY(CD0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]), .seed(seed[0]),
        .mem_data_wr(wdata[0]), .mem_data_rd(rdata[0]), .mem_data_addr(addr[0]),
        .mem_rw_data(rw[0]), .mem_valid_data(valid[0]), .mem_ready_data(ready[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]), .err_count(err_count[0]),
        .fail_addr(fail_addr[0]), .pass_count(pass_count[0])
    );

    mem_traffic_checker #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_ENTRIES(N1), .BASE_ADDR(B1), .ADDR_STRIDE(S1), .CYCLE_DELAY(CD1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]), .seed(seed[1]),
        .mem_data_wr(wdata[1]), .mem_data_rd(rdata[1]), .mem_data_addr(addr[1]),
        .mem_rw_data(rw[1]), .mem_valid_data(valid[1]), .mem_ready_data(ready[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]), .err_count(err_count[1]),
        .fail_addr(fail_addr[1]), .pass_count(pass_count[1])
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int n_of(input int g);
        return (g == 0) ? N0 : N1;
    endfunction

    function automatic int cd_of(input int g);
        return (g == 0) ? CD0 : CD1;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int g, input int i);
        logic [63:0] a;
        if (g == 0) a = 64'(B0) + 64'(i) * 64'(S0);
        else        a = 64'(B1) + 64'(i) * 64'(S1);
        return a[AW-1:0];
    endfunction

    function automatic logic [DW-1:0] pat(input logic [31:0] sd, input int i);
        logic [DW-1:0] p;
        p = '0;
        for (int k = 0; k < DW / 32; k++) p[k*32 +: 32] = sd ^ 32'((i << 16) | k);
        return p;
    endfunction

    // Memory responder: random ready latency, spurious ready while idle, hold and gap checks
    initial begin : responder
        bit            waiting [2];
        bit            pend_gap [2];
        int            wait_n [2];
        int            lat [2];
        int            gapn [2];
        logic [AW:0]   h_addr [2];
        logic [DW-1:0] h_data [2];
        cmd_t          c;
        for (int g = 0; g < 2; g++) begin
            ready[g] = 1'b0; rdata[g] = '0; waiting[g] = 0; pend_gap[g] = 0;
            wait_n[g] = 0; lat[g] = 0; gapn[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                ready[g] = 1'b0;
                if (!rst_n) begin
                    waiting[g] = 0;
                    pend_gap[g] = 0;
                end else if (valid[g]) begin
                    if (pend_gap[g]) begin
                        check($sformatf("gap_cycles%0d", g), gapn[g], cd_of(g));
                        pend_gap[g] = 0;
                    end
                    if (!waiting[g]) begin
                        waiting[g] = 1; wait_n[g] = 0;
                        lat[g] = $urandom_range(lat_hi[g], lat_lo[g]);
                        h_addr[g] = {rw[g], addr[g]};
                        h_data[g] = wdata[g];
                    end else begin
                        check($sformatf("hold_addr%0d", g), {rw[g], addr[g]}, h_addr[g]);
                        check($sformatf("hold_data%0d", g), wdata[g], h_data[g]);
                    end
                    if (wait_n[g] >= lat[g]) begin
                        ready[g] = 1'b1; waiting[g] = 0; pend_gap[g] = 1; gapn[g] = 0;
                        c.rw = rw[g];
                        c.addr = addr[g];
                        if (rw[g]) begin
                            c.data = wdata[g];
                            mem[{g[0], addr[g]}] = wdata[g];
                        end else begin
                            if (mem.exists({g[0], addr[g]})) c.data = mem[{g[0], addr[g]}];
                            else c.data = {8{$urandom}};
                            if (corrupt_idx[g] >= 0 && addr[g] == addr_of(g, corrupt_idx[g]))
                                c.data[0] = ~c.data[0];
                            rdata[g] = c.data;
                        end
                        if (g == 0) log0.push_back(c);
                        else        log1.push_back(c);
                    end else begin
                        wait_n[g]++;
                    end
                end else begin
                    waiting[g] = 0;
                    if (busy[g]) gapn[g]++;
                    else pend_gap[g] = 0;
                    ready[g] = ($urandom_range(3, 0) == 0);
                    rdata[g] = {8{$urandom}};
                end
            end
        end
    end

    // Compare the logged command stream and final status against the expected run
    task automatic check_results(input int g, input logic [1:0] m, input logic [31:0] sd, input int sweeps);
        cmd_t          got [$];
        int            n;
        int            k;
        int            errs;
        bit            do_wr;
        bit            do_rd;
        logic [AW-1:0] first;
        if (g == 0) got = log0;
        else        got = log1;
        n = n_of(g); k = 0; errs = 0; first = '0;
        do_wr = (m != 2'b10);
        do_rd = (m != 2'b01);
        check("cmd_count", got.size(), sweeps * n * (int'(do_wr) + int'(do_rd)));
        for (int s = 0; s < sweeps; s++) begin
            if (do_wr) begin
                for (int i = 0; i < n; i++) begin
                    if (k < got.size()) begin
                        check("wr_rw", got[k].rw, 1'b1);
                        check("wr_addr", got[k].addr, addr_of(g, i));
                        check("wr_data", got[k].data, pat(sd, i));
                    end
                    k++;
                end
            end
            if (do_rd) begin
                for (int i = 0; i < n; i++) begin
                    if (k < got.size()) begin
                        check("rd_rw", got[k].rw, 1'b0);
                        check("rd_addr", got[k].addr, addr_of(g, i));
                        if (got[k].data !== pat(sd, i)) begin
                            if (errs == 0) first = addr_of(g, i);
                            errs++;
                        end
                    end
                    k++;
                end
            end
        end
        check("error", error[g], errs > 0);
        check("err_count", err_count[g], errs);
        check("fail_addr", fail_addr[g], first);
        check("pass_count", pass_count[g], do_rd ? sweeps : 0);
    endtask

    task automatic run(input int g, input logic [1:0] m, input logic [31:0] sd, input int sweeps);
        int cyc;
        if (g == 0) log0.delete();
        else        log1.delete();
        seed[g] = sd; mode[g] = m; start[g] = 1'b1;
        @(negedge clk);
        check("first_valid", valid[g], 1'b1);
        if (sweeps > 1) begin
            cyc = 0;
            while (pass_count[g] != 16'(sweeps - 1) && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            check("loop_reached", cyc < 3000, 1'b1);
        end
        start[g] = 1'b0;
        cyc = 0;
        while (!done[g] && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("done", done[g], 1'b1);
        check("busy_in_done", busy[g], 1'b0);
        check_results(g, m, sd, sweeps);
        @(negedge clk);
        check("back_to_idle", done[g], 1'b0);
    endtask

    task automatic check_zero(input int g);
        check("z_valid", valid[g], 1'b0);
        check("z_rw", rw[g], 1'b0);
        check("z_addr", addr[g], '0);
        check("z_wdata", wdata[g], '0);
        check("z_busy", busy[g], 1'b0);
        check("z_done", done[g], 1'b0);
        check("z_error", error[g], 1'b0);
        check("z_err_count", err_count[g], '0);
        check("z_fail_addr", fail_addr[g], '0);
        check("z_pass_count", pass_count[g], '0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end

    initial begin : main
        int            cyc;
        logic [31:0]   s;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; mode[g] = 2'b00; seed[g] = '0;
            corrupt_idx[g] = -1; lat_lo[g] = 0; lat_hi[g] = 0;
        end
        repeat (3) @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back write+read, ready every cycle
        run(0, 2'b00, 32'hA5A5_0000, 1);
        check("entry2_lane1", (log0.size() > 2) ? log0[2].data[63:32] : 32'h0, 32'hA5A7_0001);

        // Single corrupted read of entry 3
        corrupt_idx[0] = 3;
        run(0, 2'b00, 32'hA5A5_0000, 1);
        check("t2_err_count", err_count[0], 16'd1);
        check("t2_fail_addr", fail_addr[0], 28'h160);
        corrupt_idx[0] = -1;

        // Gap instance with ready held off five cycles per command
        lat_lo[1] = 5; lat_hi[1] = 5;
        run(1, 2'b00, $urandom, 1);
        lat_lo[1] = 0; lat_hi[1] = 2;
        lat_hi[0] = 2;

        // Continuous mode, start dropped during the second pass
        run(0, 2'b11, $urandom, 2);
        check("t4_pass_count", pass_count[0], 16'd2);

        // Asynchronous reset in the middle of a pending write
        lat_lo[1] = 30; lat_hi[1] = 30;
        seed[1] = $urandom; mode[1] = 2'b00; start[1] = 1'b1;
        cyc = 0;
        while (!valid[1] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_valid_seen", valid[1], 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero(1);
        check_zero(0);
        start[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lat_lo[1] = 0; lat_hi[1] = 2;
        run(1, 2'b00, $urandom, 1);

        // Write-only then read-only with the same seed, then with a different seed
        s = $urandom;
        run(1, 2'b01, s, 1);
        run(1, 2'b10, s, 1);
        check("t6_same_seed", err_count[1], 16'd0);
        run(1, 2'b10, s ^ 32'h0001_2345, 1);
        check("t6_new_seed_cnt", err_count[1], 16'(N1));
        check("t6_new_seed_addr", fail_addr[1], 28'hFFF_FFC0);

        // Randomized runs on both instances
        for (int r = 0; r < 8; r++) begin
            int g;
            g = r % 2;
            lat_lo[g] = 0;
            lat_hi[g] = $urandom_range(3, 0);
            corrupt_idx[g] = int'($urandom_range(n_of(g), 0)) - 1;
            run(g, ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b00, $urandom, 1);
            corrupt_idx[g] = -1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
